// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and helpers for the byte_mem memory slice.
//   mem_state_t : access FSM states (IDLE/BUSY/DONE)
//   byte_num_t  : 3-bit byte count carried with every request
//   mem_legal() : request legality check (byte count range + address bound)
// -----------------------------------------------------------------------------
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   typedef logic [2:0] byte_num_t;

   // Widest address port the legality helper accepts.
   localparam int unsigned MAX_ADDR_W = 64;

   // Legal iff 1 <= byte_num <= max_bytes and addr + byte_num <= depth.
   // The sum is formed one bit wider than the address so it cannot wrap.
   function automatic logic mem_legal(input logic [MAX_ADDR_W-1:0] addr,
                                      input byte_num_t             byte_num,
                                      input int unsigned           depth,
                                      input int unsigned           max_bytes);
      logic [MAX_ADDR_W:0] end_addr;
      end_addr = {1'b0, addr} + {{(MAX_ADDR_W-2){1'b0}}, byte_num};
      return (byte_num != '0) &&
             ({29'b0, byte_num} <= max_bytes) &&
             (end_addr <= {33'b0, depth});
   endfunction

endpackage

// File: rtl/byte_mem_if.sv
// -----------------------------------------------------------------------------
// byte_mem_if
// Request/response bundle between a requester and byte_mem.
//   rd_en/rd_addr/rd_byte_num -> ; <- rd_data/rd_done/rd_err
//   wr_en/wr_addr/wr_data/wr_byte_num -> ; <- wr_done/wr_err
// master : requester side, slave : memory side.
// -----------------------------------------------------------------------------
interface byte_mem_if
   import mem_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32
);

   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   byte_num_t         rd_byte_num;
   logic [DATA_W-1:0] rd_data;
   logic              rd_done;
   logic              rd_err;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   byte_num_t         wr_byte_num;
   logic              wr_done;
   logic              wr_err;

   modport master (
      output rd_en, rd_addr, rd_byte_num,
      input  rd_data, rd_done, rd_err,
      output wr_en, wr_addr, wr_data, wr_byte_num,
      input  wr_done, wr_err
   );

   modport slave (
      input  rd_en, rd_addr, rd_byte_num,
      output rd_data, rd_done, rd_err,
      input  wr_en, wr_addr, wr_data, wr_byte_num,
      output wr_done, wr_err
   );

endinterface

// File: rtl/byte_array.sv
// -----------------------------------------------------------------------------
// byte_array
// DEPTH x 8 storage with synchronous clear, one multi-byte write port with
// per-lane enables and one combinational multi-byte read port.
//   clk          : clock
//   clr_i        : synchronous clear of every byte (wins over writes)
//   wr_addr_i    : byte address of write lane 0
//   wr_lane_en_i : per-lane write enables, lane i goes to wr_addr_i + i
//   wr_data_i    : write data, lane i at bits [8i+7:8i]
//   rd_addr_i    : byte address of read lane 0
//   rd_data_o    : lane i holds byte rd_addr_i + i (0 if beyond DEPTH)
// -----------------------------------------------------------------------------
module byte_array #(
   parameter int unsigned DEPTH  = 128,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned NB     = 4
) (
   input  logic              clk,
   input  logic              clr_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [NB-1:0]     wr_lane_en_i,
   input  logic [8*NB-1:0]   wr_data_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [8*NB-1:0]   rd_data_o
);

   localparam int unsigned       IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

   logic [7:0]        mem_q [DEPTH];
   logic [ADDR_W-1:0] wa [NB];
   logic [ADDR_W-1:0] ra [NB];

   always_comb begin
      for (int unsigned l = 0; l < NB; l++) begin
         wa[l] = wr_addr_i + ADDR_W'(l);
         ra[l] = rd_addr_i + ADDR_W'(l);
      end
   end

   always_ff @(posedge clk) begin
      if (clr_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int unsigned l = 0; l < NB; l++) begin
            if (wr_lane_en_i[l] && (wa[l] < DEPTH_A)) begin
               mem_q[wa[l][IW-1:0]] <= wr_data_i[8*l +: 8];
            end
         end
      end
   end

   always_comb begin
      rd_data_o = '0;
      for (int unsigned l = 0; l < NB; l++) begin
         if (ra[l] < DEPTH_A) begin
            rd_data_o[8*l +: 8] = mem_q[ra[l][IW-1:0]];
         end
      end
   end

endmodule

// File: rtl/byte_mem.sv
// -----------------------------------------------------------------------------
// byte_mem
// Byte-addressed on-chip memory with separate read/write request ports, a
// programmable access latency and en/done handshaking. Accesses are
// little-endian, 1..DATA_W/8 bytes, serialised by one FSM; writes win ties.
//   clk : clock
//   rst : synchronous active-high reset (also clears the storage)
//   bus : byte_mem_if slave port (read and write request/response)
// -----------------------------------------------------------------------------
module byte_mem
   import mem_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DEPTH   = 128,
   parameter int unsigned LATENCY = 1
) (
   input  logic       clk,
   input  logic       rst,
   byte_mem_if.slave  bus
);

   localparam int unsigned NB = DATA_W / 8;

   if ((LATENCY < 1) || (LATENCY > 15)) begin : g_bad_latency
      $error("byte_mem: LATENCY must be in 1..15");
   end
   if (((DATA_W % 8) != 0) || (DATA_W == 0) || (DATA_W > 64)) begin : g_bad_data_w
      $error("byte_mem: DATA_W must be a non-zero multiple of 8, at most 64");
   end
   if ((ADDR_W > MAX_ADDR_W) || ($clog2(DEPTH) > ADDR_W)) begin : g_bad_addr_w
      $error("byte_mem: ADDR_W out of range for DEPTH");
   end

   mem_state_t        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              is_wr_q, is_wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   byte_num_t         num_q, num_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              err_q, err_d;

   logic              legal;
   logic              commit;
   logic [NB-1:0]     lane_en;
   logic [DATA_W-1:0] arr_rdata;
   logic [DATA_W-1:0] rd_masked;

   assign legal  = mem_legal(MAX_ADDR_W'(addr_q), num_q, DEPTH, NB);
   assign commit = (state_q == BUSY) && (cnt_q == '0);

   // Lanes at or above byte_num are neither written nor returned.
   always_comb begin
      lane_en   = '0;
      rd_masked = '0;
      for (int unsigned l = 0; l < NB; l++) begin
         if (byte_num_t'(l) < num_q) begin
            lane_en[l]          = commit && is_wr_q && legal;
            rd_masked[8*l +: 8] = arr_rdata[8*l +: 8];
         end
      end
   end

   byte_array #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .NB     (NB)
   ) u_array (
      .clk          (clk),
      .clr_i        (rst),
      .wr_addr_i    (addr_q),
      .wr_lane_en_i (lane_en),
      .wr_data_i    (wdata_q),
      .rd_addr_i    (addr_q),
      .rd_data_o    (arr_rdata)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_wr_d   = is_wr_q;
      addr_d    = addr_q;
      num_d     = num_q;
      wdata_d   = wdata_q;
      rd_data_d = rd_data_q;
      err_d     = err_q;
      unique case (state_q)
         IDLE: begin
            if (bus.wr_en) begin
               state_d = BUSY;
               cnt_d   = 4'(LATENCY - 1);
               is_wr_d = 1'b1;
               addr_d  = bus.wr_addr;
               num_d   = bus.wr_byte_num;
               wdata_d = bus.wr_data;
            end else if (bus.rd_en) begin
               state_d = BUSY;
               cnt_d   = 4'(LATENCY - 1);
               is_wr_d = 1'b0;
               addr_d  = bus.rd_addr;
               num_d   = bus.rd_byte_num;
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               state_d = DONE;
               err_d   = !legal;
               if (!is_wr_q) begin
                  rd_data_d = legal ? rd_masked : '0;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         is_wr_q   <= 1'b0;
         addr_q    <= '0;
         num_q     <= '0;
         wdata_q   <= '0;
         rd_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_wr_q   <= is_wr_d;
         addr_q    <= addr_d;
         num_q     <= num_d;
         wdata_q   <= wdata_d;
         rd_data_q <= rd_data_d;
         err_q     <= err_d;
      end
   end

   // done/err are decoded from the single DONE cycle of the matching access.
   assign bus.wr_done = (state_q == DONE) &&  is_wr_q;
   assign bus.rd_done = (state_q == DONE) && !is_wr_q;
   assign bus.wr_err  = bus.wr_done && err_q;
   assign bus.rd_err  = bus.rd_done && err_q;
   assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_byte_mem.sv
// -----------------------------------------------------------------------------
// tb_byte_mem
// Directed, table-driven bench for byte_mem. Instance dut3 uses LATENCY=3,
// instance dut4 uses LATENCY=4 for the reset-mid-access sequence.
// -----------------------------------------------------------------------------
module tb_byte_mem;
   import mem_pkg::*;

   logic clk  = 1'b0;
   logic rst3 = 1'b1;
   logic rst4 = 1'b1;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   byte_mem_if #(.DATA_W(32), .ADDR_W(32)) bus3 ();
   byte_mem_if #(.DATA_W(32), .ADDR_W(32)) bus4 ();

   byte_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(128), .LATENCY(3)) dut3 (
      .clk (clk),
      .rst (rst3),
      .bus (bus3)
   );

   byte_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(128), .LATENCY(4)) dut4 (
      .clk (clk),
      .rst (rst4),
      .bus (bus4)
   );

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      byte_num_t   num;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;   // rd_data expected after this access completes
   } vec_t;

   vec_t vecs [17];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one request from IDLE (called #1 after a posedge), wait for its
   // done, check latency/err/rd_data, then return with the DUT back in IDLE.
   task automatic do_req(virtual byte_mem_if #(.DATA_W(32), .ADDR_W(32)) vif,
                         input int lat, input string tag, input logic wr,
                         input logic [31:0] addr, input byte_num_t num,
                         input logic [31:0] wdata, input logic exp_err,
                         input logic [31:0] exp_rdata);
      int n;
      int other;
      bit got;
      logic err;
      if (wr) begin
         vif.wr_en = 1'b1; vif.wr_addr = addr; vif.wr_byte_num = num; vif.wr_data = wdata;
      end else begin
         vif.rd_en = 1'b1; vif.rd_addr = addr; vif.rd_byte_num = num;
      end
      @(posedge clk);           // acceptance edge
      n = 0; other = 0; got = 1'b0; err = 1'b0;
      while (!got && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (wr ? vif.rd_done : vif.wr_done) other++;
         if (wr ? vif.wr_done : vif.rd_done) begin
            got = 1'b1;
            err = wr ? vif.wr_err : vif.rd_err;
         end
      end
      chk({tag, "_latency"}, 64'(n), 64'(lat));
      chk({tag, "_err"}, 64'(err), 64'(exp_err));
      chk({tag, "_rd_data"}, 64'(vif.rd_data), 64'(exp_rdata));
      chk({tag, "_other_done"}, 64'(other), 64'd0);
      vif.wr_en = 1'b0;
      vif.rd_en = 1'b0;
      @(posedge clk); #1;       // DONE -> IDLE
      chk({tag, "_done_pulse"}, 64'(wr ? vif.wr_done : vif.rd_done), 64'd0);
   endtask

   initial begin
      int n;
      int spurious;
      bit got;

      vecs[0]  = '{1'b0, 32'd0,          3'd0 + 3'd4, 32'h0,        1'b0, 32'h0000_0000};
      vecs[1]  = '{1'b1, 32'd5,          3'd4, 32'hDEAD_BEEF,      1'b0, 32'h0000_0000};
      vecs[2]  = '{1'b0, 32'd6,          3'd2, 32'h0,              1'b0, 32'h0000_ADBE};
      vecs[3]  = '{1'b0, 32'd7,          3'd2, 32'h0,              1'b0, 32'h0000_DEAD};
      vecs[4]  = '{1'b1, 32'd127,        3'd1, 32'h0000_0011,      1'b0, 32'h0000_DEAD};
      vecs[5]  = '{1'b1, 32'd127,        3'd2, 32'h0000_2233,      1'b1, 32'h0000_DEAD};
      vecs[6]  = '{1'b0, 32'd127,        3'd1, 32'h0,              1'b0, 32'h0000_0011};
      vecs[7]  = '{1'b0, 32'd124,        3'd4, 32'h0,              1'b0, 32'h1100_0000};
      vecs[8]  = '{1'b0, 32'd125,        3'd4, 32'h0,              1'b1, 32'h0000_0000};
      vecs[9]  = '{1'b0, 32'd0,          3'd0, 32'h0,              1'b1, 32'h0000_0000};
      vecs[10] = '{1'b1, 32'd20,         3'd4, 32'hFFFF_FFFF,      1'b0, 32'h0000_0000};
      vecs[11] = '{1'b1, 32'd20,         3'd1, 32'h1234_56AB,      1'b0, 32'h0000_0000};
      vecs[12] = '{1'b0, 32'd20,         3'd4, 32'h0,              1'b0, 32'hFFFF_FFAB};
      vecs[13] = '{1'b1, 32'd40,         3'd0, 32'h7777_7777,      1'b1, 32'hFFFF_FFAB};
      vecs[14] = '{1'b0, 32'hFFFF_FFFF,  3'd1, 32'h0,              1'b1, 32'h0000_0000};
      vecs[15] = '{1'b0, 32'd5,          3'd4, 32'h0,              1'b0, 32'hDEAD_BEEF};
      vecs[16] = '{1'b0, 32'd3,          3'd5, 32'h0,              1'b1, 32'h0000_0000};

      bus3.rd_en = 1'b0; bus3.rd_addr = '0; bus3.rd_byte_num = '0;
      bus3.wr_en = 1'b0; bus3.wr_addr = '0; bus3.wr_byte_num = '0; bus3.wr_data = '0;
      bus4.rd_en = 1'b0; bus4.rd_addr = '0; bus4.rd_byte_num = '0;
      bus4.wr_en = 1'b0; bus4.wr_addr = '0; bus4.wr_byte_num = '0; bus4.wr_data = '0;

      repeat (2) @(posedge clk);
      #1;
      rst3 = 1'b0;
      rst4 = 1'b0;
      chk("reset_rd_done", 64'(bus3.rd_done), 64'd0);
      chk("reset_wr_done", 64'(bus3.wr_done), 64'd0);
      chk("reset_rd_err",  64'(bus3.rd_err),  64'd0);
      chk("reset_wr_err",  64'(bus3.wr_err),  64'd0);
      chk("reset_rd_data", 64'(bus3.rd_data), 64'd0);

      // Single-port vectors, LATENCY=3.
      for (int i = 0; i < 17; i++) begin
         do_req(bus3, 3, $sformatf("v%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].num,
                vecs[i].wdata, vecs[i].err, vecs[i].rdata);
      end

      // Simultaneous write and read of address 10: write first, read sees it.
      bus3.wr_en = 1'b1; bus3.wr_addr = 32'd10; bus3.wr_byte_num = 3'd1; bus3.wr_data = 32'h0000_005A;
      bus3.rd_en = 1'b1; bus3.rd_addr = 32'd10; bus3.rd_byte_num = 3'd1;
      @(posedge clk);
      n = 0; got = 1'b0; spurious = 0;
      while (!got && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (bus3.rd_done) spurious++;
         if (bus3.wr_done) got = 1'b1;
      end
      chk("both_wr_latency", 64'(n), 64'd3);
      chk("both_rd_not_first", 64'(spurious), 64'd0);
      bus3.wr_en = 1'b0;
      n = 0; got = 1'b0;
      while (!got && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (bus3.rd_done) got = 1'b1;
      end
      chk("both_rd_done_seen", 64'(got), 64'd1);
      chk("both_rd_data", 64'(bus3.rd_data), 64'h5A);
      chk("both_rd_err", 64'(bus3.rd_err), 64'd0);
      bus3.rd_en = 1'b0;
      @(posedge clk); #1;

      // Reset mid-access, LATENCY=4.
      do_req(bus4, 4, "l4_wr0", 1'b1, 32'd0, 3'd4, 32'hCAFE_F00D, 1'b0, 32'h0);
      do_req(bus4, 4, "l4_rd0", 1'b0, 32'd0, 3'd4, 32'h0, 1'b0, 32'hCAFE_F00D);
      bus4.wr_en = 1'b1; bus4.wr_addr = 32'd8; bus4.wr_byte_num = 3'd4; bus4.wr_data = 32'h0102_0304;
      @(posedge clk);           // acceptance edge T
      spurious = 0;
      repeat (2) begin
         @(posedge clk); #1;
         if (bus4.wr_done) spurious++;
      end
      rst4 = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         if (bus4.wr_done) spurious++;
      end
      rst4 = 1'b0;
      chk("rst_no_wr_done", 64'(spurious), 64'd0);
      chk("rst_rd_data_cleared", 64'(bus4.rd_data), 64'd0);
      @(posedge clk);           // first non-reset edge re-accepts the held write
      n = 0; got = 1'b0;
      while (!got && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (bus4.wr_done) got = 1'b1;
      end
      chk("rst_reaccept_latency", 64'(n), 64'd4);
      chk("rst_reaccept_err", 64'(bus4.wr_err), 64'd0);
      bus4.wr_en = 1'b0;
      @(posedge clk); #1;
      do_req(bus4, 4, "l4_rd_cleared", 1'b0, 32'd0, 3'd4, 32'h0, 1'b0, 32'h0);
      do_req(bus4, 4, "l4_rd_rewritten", 1'b0, 32'd8, 3'd4, 32'h0, 1'b0, 32'h0102_0304);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
